seven_seg_scan_driver: RTL and testbench

Downstream consumer of the display rotation stage. Takes the 4-digit BCD word and decimal-point flag selected by the rotation stage and time-multiplexes them onto a common-anode 4-digit seven-segment display. It snapshots each frame to prevent tearing, inserts an anti-ghosting blank interval per digit, applies leading-zero blanking, and decodes invalid BCD codes to a dash.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/seven_seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count,
// active-low segment patterns {g,f,e,d,c,b,a}, anode-off pattern, digit index type.
// Pure declarations, no logic.
package seg_pkg;

    localparam int DIGITS = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 render as a dash.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   bcd  in  4  BCD code
//   seg  out 7  segment pattern {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexes a snapshotted 4-digit BCD word onto a common-anode display.
// Latency: seg/dp_n/an registered, 1 cycle behind the slot counter/index state.
// Backpressure: none; free-running scan, inputs sampled once per frame.
//
// Ports:
//   clk100Mhz   in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   display_bcd in  16  four BCD digits, [3:0] = digit 0 (rightmost)
//   dp          in   1  decimal-point request
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n        out  1  decimal-point segment, active-low
//   an          out  4  anode enables, active-low, an[k] = digit k
//   frame_tick  out  1  one-cycle pulse when a new snapshot is taken
module seven_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int DP_DIGIT     = 2,
    parameter int LZ_BLANK     = 1
)(
    input  logic        clk100Mhz,
    input  logic        rst_n,
    input  logic [15:0] display_bcd,
    input  logic        dp,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int         CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam digit_idx_t DP_IDX = digit_idx_t'(DP_DIGIT);

    if (REFRESH_DIV <= BLANK_CYCLES) begin : g_param_check
        $fatal(1, "seven_seg_scan_driver: REFRESH_DIV must exceed BLANK_CYCLES");
    end

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic [15:0]   snap_bcd;
    logic          snap_dp;

    logic          load;
    logic          cnt_wrap;
    logic          drive;
    logic [15:0]   cur_bcd;
    logic          cur_dp;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic [3:0]    digit_zero;
    logic [3:0]    lz_run;
    logic          blank_digit;

    assign load     = (cnt == '0) && (idx == '0);
    assign cnt_wrap = (cnt == CW'(REFRESH_DIV - 1));
    assign drive    = !(cnt < CW'(BLANK_CYCLES));

    // On the snapshot cycle the registers are being loaded on this same edge,
    // so decode from the incoming word to keep output and snapshot consistent.
    assign cur_bcd   = load ? display_bcd : snap_bcd;
    assign cur_dp    = load ? dp          : snap_dp;
    assign cur_digit = cur_bcd[{idx, 2'b00} +: 4];

    always_comb begin
        digit_zero = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digit_zero[k] = (cur_bcd[4*k +: 4] == 4'd0);
        end
    end

    // lz_run[k]: digit k and every digit above it are zero
    assign lz_run[3] = digit_zero[3];
    assign lz_run[2] = lz_run[3] & digit_zero[2];
    assign lz_run[1] = lz_run[2] & digit_zero[1];
    assign lz_run[0] = lz_run[1] & digit_zero[0];

    // Digit 0 always shows; with the decimal point lit, digits up to the
    // point stay visible so "0.05"-style values keep their integer zero.
    assign blank_digit = (LZ_BLANK != 0) && (idx != '0) && lz_run[idx]
                         && !(cur_dp && (idx <= DP_IDX));

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            snap_bcd   <= '0;
            snap_dp    <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            an         <= AN_OFF;
        end else begin
            frame_tick <= load;
            if (load) begin
                snap_bcd <= display_bcd;
                snap_dp  <= dp;
            end

            if (cnt_wrap) begin
                cnt <= '0;
                idx <= digit_idx_t'(idx + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (drive && !blank_digit) begin
                an  <= ~(4'b0001 << idx);
                seg <= dec_seg;
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
            end

            dp_n <= !(drive && cur_dp && (idx == DP_IDX));
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] display_bcd = '0;
    logic        dp = 1'b0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .DP_DIGIT     (2),
        .LZ_BLANK     (1)
    ) dut (
        .clk100Mhz   (clk),
        .rst_n       (rst_n),
        .display_bcd (display_bcd),
        .dp          (dp),
        .seg         (seg),
        .dp_n        (dp_n),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       chk_seg;
        logic       dp_n;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at each falling edge, compare every expectation due by now
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                if (an !== e.an || dp_n !== e.dp_n || frame_tick !== e.ft ||
                    (e.chk_seg && seg !== e.seg)) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got an=%b seg=%b dp_n=%b ft=%b want an=%b seg=%b(chk=%b) dp_n=%b ft=%b",
                             e.name, cyc, an, seg, dp_n, frame_tick,
                             e.an, e.seg, e.chk_seg, e.dp_n, e.ft);
                end
            end
        end
    end

    task automatic push_reset(input string nm, input int tgt);
        exp_t e;
        e.cyc = tgt; e.name = nm; e.an = 4'b1111; e.seg = 7'b1111111;
        e.chk_seg = 1'b1; e.dp_n = 1'b1; e.ft = 1'b0;
        q.push_back(e);
    endtask

    // One digit slot: 2 blank cycles then drive cycles with the given outputs
    task automatic slot(input string nm, input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic dpn_e, input logic ft_e, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            exp_t e;
            e.cyc = cyc + 1;
            e.name = nm;
            if (c < 2) begin
                e.an = 4'b1111; e.seg = 7'b1111111; e.chk_seg = 1'b0; e.dp_n = 1'b1;
            end else begin
                e.an = an_e; e.seg = seg_e; e.chk_seg = 1'b1; e.dp_n = dpn_e;
            end
            e.ft = ft_e && (c == 0);
            q.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    // Full frame: s0..s3 hand-decoded patterns, blank[k]=1 keeps digit k dark,
    // dp2=1 expects the decimal point on digit 2.
    task automatic frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] blank, input logic dp2);
        logic [6:0] s [4];
        logic [3:0] an_tab [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            slot($sformatf("%s_d%0d", nm, k),
                 blank[k] ? 4'b1111 : an_tab[k],
                 blank[k] ? 7'b1111111 : s[k],
                 !(dp2 && k == 2), (k == 0), 8);
        end
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            display_bcd = 16'($urandom);
            dp = 1'($urandom);
            push_reset("reset_hold", cyc + 1);
            @(posedge clk); #1;
        end

        // 1234, dp=0: two identical frames, first load on first edge after release
        display_bcd = 16'h1234; dp = 1'b0;
        rst_n = 1'b1;
        frame("f1234a", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b0000, 1'b0);
        frame("f1234b", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b0000, 1'b0);

        // Input change during digit-1 slot must not tear the frame
        slot("tear_d0", 4'b1110, 7'b0011001, 1'b1, 1'b1, 8);
        display_bcd = 16'h9876;
        slot("tear_d1", 4'b1101, 7'b0110000, 1'b1, 1'b0, 8);
        slot("tear_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0, 8);
        slot("tear_d3", 4'b0111, 7'b1111001, 1'b1, 1'b0, 8);
        frame("f9876", 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 4'b0000, 1'b0);

        // 0567 with dp: digit 3 blanked, dp on digit 2
        display_bcd = 16'h0567; dp = 1'b1;
        frame("f0567dp", 7'b1111000, 7'b0000010, 7'b0010010, 7'b1111111, 4'b1000, 1'b1);

        // 0007 with dp: zeros at/below the point stay lit
        display_bcd = 16'h0007; dp = 1'b1;
        frame("f0007dp", 7'b1111000, 7'b1000000, 7'b1000000, 7'b1111111, 4'b1000, 1'b1);

        // 00A0: dash on digit 1, digits 2-3 blanked
        display_bcd = 16'h00A0; dp = 1'b0;
        frame("f00A0", 7'b1000000, 7'b0111111, 7'b1111111, 7'b1111111, 4'b1100, 1'b0);

        // 0000: only digit 0 shown
        display_bcd = 16'h0000; dp = 1'b0;
        frame("f0000", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1110, 1'b0);

        // F00E: non-zero top digit suppresses blanking, both ends dashes
        display_bcd = 16'hF00E; dp = 1'b0;
        frame("fF00E", 7'b0111111, 7'b1000000, 7'b1000000, 7'b0111111, 4'b0000, 1'b0);

        // Async reset in the middle of digit-2 drive
        display_bcd = 16'h1234; dp = 1'b0;
        slot("rst_d0", 4'b1110, 7'b0011001, 1'b1, 1'b1, 8);
        slot("rst_d1", 4'b1101, 7'b0110000, 1'b1, 1'b0, 8);
        slot("rst_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        push_reset("rst_async", cyc);
        for (int i = 0; i < 2; i++) begin
            display_bcd = 16'($urandom);
            push_reset("rst_hold2", cyc + 1);
            @(posedge clk); #1;
        end
        display_bcd = 16'h1234;
        rst_n = 1'b1;
        frame("f_restart", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b0000, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
